// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. Takes a WIDTH-bit word through a valid/ready
// handshake and emits it one bit per clock on a registered sdata with a frame strobe.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdata,
  output logic             sdata_b,
  output logic             svalid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    count, count_nx;
  logic             sdata_nx;
  logic             svalid_nx;
  logic             last_bit;
  logic             accept;

  // A new word may be taken when idle or while the final bit of the current word is out.
  assign last_bit   = (state == SHIFT) && (count == '0);
  assign load_ready = !reset && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;
  assign done       = last_bit;
  assign sdata_b    = ~sdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      count  <= '0;
      sdata  <= 1'b0;
      svalid <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      count  <= count_nx;
      sdata  <= sdata_nx;
      svalid <= svalid_nx;
    end
  end

  // The first bit goes straight to sdata on accept; shreg keeps the rest, zero-filled.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    count_nx  = count;
    sdata_nx  = 1'b0;
    svalid_nx = 1'b0;

    if (accept) begin
      state_nx  = SHIFT;
      svalid_nx = 1'b1;
      count_nx  = CW'(WIDTH - 1);
      if (MSB_FIRST) begin
        sdata_nx = load_data[WIDTH-1];
        shreg_nx = {load_data[WIDTH-2:0], 1'b0};
      end else begin
        sdata_nx = load_data[0];
        shreg_nx = {1'b0, load_data[WIDTH-1:1]};
      end
    end else begin
      case (state)
        IDLE: begin
          state_nx = IDLE;
        end
        SHIFT: begin
          if (count != '0) begin
            svalid_nx = 1'b1;
            count_nx  = count - CW'(1);
            if (MSB_FIRST) begin
              sdata_nx = shreg[WIDTH-1];
              shreg_nx = {shreg[WIDTH-2:0], 1'b0};
            end else begin
              sdata_nx = shreg[0];
              shreg_nx = {1'b0, shreg[WIDTH-1:1]};
            end
          end else begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance, with a
// per-lane queue of expected serial bits pushed at each modelled accept.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       lv0, lv1;
  logic [7:0] ld0, ld1;
  logic [1:0] rdy, sd, sdb, sv, dn;

  int checks = 0;
  int errors = 0;
  bit q0[$];
  bit q1[$];
  bit acc;
  int n;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .reset     (reset),
    .load_data (ld0),
    .load_valid(lv0),
    .load_ready(rdy[0]),
    .sdata     (sd[0]),
    .sdata_b   (sdb[0]),
    .svalid    (sv[0]),
    .done      (dn[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .load_data (ld1),
    .load_valid(lv1),
    .load_ready(rdy[1]),
    .sdata     (sd[1]),
    .sdata_b   (sdb[1]),
    .svalid    (sv[1]),
    .done      (dn[1])
  );

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // While reset is high every output sits at its reset value, with no clock needed.
  task automatic checkReset(input string tag);
    for (int l = 0; l < 2; l++) begin
      checkOutput($sformatf("%s_sdata_l%0d", tag, l), sd[l], 1'b0);
      checkOutput($sformatf("%s_sdata_b_l%0d", tag, l), sdb[l], 1'b1);
      checkOutput($sformatf("%s_svalid_l%0d", tag, l), sv[l], 1'b0);
      checkOutput($sformatf("%s_done_l%0d", tag, l), dn[l], 1'b0);
      checkOutput($sformatf("%s_ready_l%0d", tag, l), rdy[l], 1'b0);
    end
  endtask

  task automatic sampleLane(input int lane);
    logic b, last, exp_sv;
    b = 1'b0; last = 1'b0; exp_sv = 1'b0;
    if (lane == 0 && q0.size() > 0) begin
      b = q0.pop_front(); last = (q0.size() == 0); exp_sv = 1'b1;
    end else if (lane == 1 && q1.size() > 0) begin
      b = q1.pop_front(); last = (q1.size() == 0); exp_sv = 1'b1;
    end
    checkOutput($sformatf("svalid_l%0d", lane), sv[lane], exp_sv);
    checkOutput($sformatf("sdata_l%0d", lane), sd[lane], b);
    checkOutput($sformatf("sdata_b_l%0d", lane), sdb[lane], ~b);
    checkOutput($sformatf("done_l%0d", lane), dn[lane], last);
  endtask

  // Drives one cycle of input on a lane, checks ready, and scores both lanes after the edge.
  task automatic applyStimulus(input int lane, input logic valid, input logic [7:0] data,
                               output bit accepted);
    logic exp_rdy0, exp_rdy1;
    lv0 = (lane == 0) && valid;
    lv1 = (lane == 1) && valid;
    if (lane == 0) ld0 = data; else ld1 = data;
    exp_rdy0 = !reset && (q0.size() == 0);
    exp_rdy1 = !reset && (q1.size() == 0);
    #1;
    checkOutput("load_ready_l0", rdy[0], exp_rdy0);
    checkOutput("load_ready_l1", rdy[1], exp_rdy1);
    accepted = valid && ((lane == 0) ? exp_rdy0 : exp_rdy1);
    @(posedge clk);
    #1;
    if (accepted) begin
      for (int i = 0; i < 8; i++) begin
        if (lane == 0) q0.push_back(data[7-i]);
        else           q1.push_back(data[i]);
      end
    end
    sampleLane(0);
    sampleLane(1);
  endtask

  task automatic idleCycles(input int cycles);
    bit a;
    for (int i = 0; i < cycles; i++) applyStimulus(0, 1'b0, 8'h00, a);
  endtask

  initial begin
    reset = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0;
    ld0 = 8'h00; ld1 = 8'h00;
    #1;
    checkReset("reset_t0");
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset_held");
    reset = 1'b0;
    idleCycles(2);

    $display("[TB] single word 0xA5 MSB first");
    applyStimulus(0, 1'b1, 8'hA5, acc);
    idleCycles(9);

    $display("[TB] back-to-back 0xA5 then 0x3C");
    applyStimulus(0, 1'b1, 8'hA5, acc);
    n = 0;
    do begin
      applyStimulus(0, 1'b1, 8'h3C, acc);
      n++;
    end while (!acc && n < 20);
    idleCycles(9);

    $display("[TB] LSB first 0x01");
    applyStimulus(1, 1'b1, 8'h01, acc);
    idleCycles(9);

    $display("[TB] hold-off 0xFF behind 0x00");
    applyStimulus(0, 1'b1, 8'h00, acc);
    applyStimulus(0, 1'b0, 8'h5A, acc);
    n = 0;
    do begin
      applyStimulus(0, 1'b1, 8'hFF, acc);
      n++;
    end while (!acc && n < 20);
    idleCycles(9);

    $display("[TB] async reset during bit 4 of 0xA5");
    applyStimulus(0, 1'b1, 8'hA5, acc);
    idleCycles(4);
    #2 reset = 1'b1;
    #1;
    checkReset("reset_async");
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    checkReset("reset_edge");
    #2 reset = 1'b0;
    applyStimulus(0, 1'b1, 8'h3C, acc);
    idleCycles(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Produces the registered serial bit stream that our D-flip-flop capture/shift chains sample on `clk`.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
- Emits a frame-valid strobe and a last-bit pulse alongside the data.
- Supports gapless back-to-back words.

Parameters:
- WIDTH, 8: word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load_data  input  WIDTH  parallel word to transmit
- load_valid  input  1  load_data is valid
- load_ready  output  1  serializer can accept a word this cycle
- sdata  output  1  serial data, registered
- sdata_b  output  1  complement of sdata, always ~sdata
- svalid  output  1  sdata carries a frame bit this cycle, registered
- done  output  1  high during the cycle the final bit of a word is on sdata

Behaviour:
- Interface: one clock, `clk`. Reset is `reset`, asynchronous and active-high. All state updates on posedge clk or posedge reset.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; shift register=0; bit counter=0.
  - sdata=0, sdata_b=1, svalid=0, done=0.
  - load_ready=0 while reset is high.
  - Any in-flight word is discarded with no partial completion. The first edge after reset deasserts is an IDLE edge.
- State machine has two states:
  - IDLE: svalid=0, sdata=0, done=0.
  - SHIFT: a word is being emitted.
- load_ready = !reset && (state==IDLE || (state==SHIFT && count==0)). It is combinational from registered state only, with no path from load_valid.
- Accept occurs on a rising edge where load_valid && load_ready. At that edge:
  - The word is captured.
  - sdata is set to the first bit (bit WIDTH-1 if MSB_FIRST, else bit 0).
  - svalid=1, count=WIDTH-1, state=SHIFT.
- Latency: the first bit appears in the cycle after the accept edge. Bit k (0-based) is on sdata during cycle k+1 after accept.
- In SHIFT with count>0, each edge:
  - Shifts the register toward the output end and presents the next bit.
  - Decrements count by 1.
  - load_data and load_valid are ignored (load_ready=0).
- In SHIFT with count==0 (last bit on sdata):
  - done=1 combinationally from (state==SHIFT && count==0). Exactly one cycle per word.
  - Next edge with load_valid=1: accept the new word. Gapless, svalid stays 1, the new first bit follows immediately, and done falls.
  - Next edge with load_valid=0: go to IDLE, svalid=0, sdata=0.
- sdata_b is combinational ~sdata at all times, including during reset.
- Width rules:
  - count is $clog2(WIDTH) bits and never wraps below 0.
  - Vacated shift positions fill with 0.
- Simultaneous events:
  - Reset wins over any accept.
  - load_valid asserted throughout SHIFT is held off, not lost. The word is accepted at the count==0 edge if still presented.
- load_data is only sampled at the accept edge; changes at other times have no effect.

Test Plan:
- Reset, then present 0xA5 with load_valid for one cycle (WIDTH=8, MSB_FIRST=1) -> sdata=1,0,1,0,0,1,0,1 on cycles 1..8 after accept; svalid=1 for exactly those 8 cycles; done=1 only on cycle 8; then sdata=0, svalid=0, load_ready=1.
- Back-to-back: 0xA5 then 0x3C with load_valid held high -> 16 contiguous svalid cycles carrying 10100101 00111100; done on cycles 8 and 16; load_ready high only on cycles 0 and 8.
- MSB_FIRST=0 with 0x01 -> sdata=1,0,0,0,0,0,0,0; done on cycle 8.
- Hold-off: load_valid=1 with 0xFF presented while busy on 0x00 from cycle 2 -> 0xFF not accepted until the count==0 edge; output 00000000 then 11111111 gapless.
- Async reset asserted mid-edge at bit 4 of 0xA5 -> outputs go to sdata=0, sdata_b=1, svalid=0, done=0 immediately without waiting for a clock edge. After release, the next frame of 0x3C transmits cleanly with no residue.
- Throughout every scenario, check sdata_b == ~sdata every cycle.
